// File: rtl/fault_sim_pkg.sv
// Shared types and sizing helpers for the serial fault-simulation sequencer.
package fault_sim_pkg;

  localparam int STATE_W    = 3;
  localparam int VEC_AW_DEF = 4;

  // Vector index carries one extra bit so a full memory (2^VEC_AW entries) is countable.
  function automatic int vec_cnt_w(input int aw);
    return aw + 1;
  endfunction

  localparam int VEC_CNT_W = vec_cnt_w(VEC_AW_DEF);

  typedef enum logic [STATE_W-1:0] {
    S_IDLE,
    S_INJECT,
    S_FETCH,
    S_APPLY,
    S_COMPARE,
    S_DROP,
    S_FIN
  } state_t;

endpackage

// File: rtl/fault_sim_settle_cnt.sv
// Loadable down-counter timing how long a vector is held before comparison.
module fault_sim_settle_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fault_sim_ctrl.sv
// Clocked fault loop: inject, walk vectors, compare good/faulty outputs, drop on first detection.
// vec_data is sampled at the clock edge that closes the FETCH cycle.
module fault_sim_ctrl
  import fault_sim_pkg::*;
#(
  parameter int NUM_IN  = 6,
  parameter int VEC_AW  = VEC_AW_DEF,
  parameter int FAULT_W = 8,
  parameter int SETTLE  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FAULT_W-1:0] num_faults,
  input  logic [VEC_AW:0]    num_vecs,
  output logic [VEC_AW-1:0]  vec_addr,
  input  logic [NUM_IN-1:0]  vec_data,
  output logic [NUM_IN-1:0]  pi_vec,
  output logic               fault_en,
  output logic [FAULT_W-1:0] fault_id,
  input  logic               out_good,
  input  logic               out_faulty,
  output logic               det_valid,
  output logic [FAULT_W-1:0] det_fault_id,
  output logic [NUM_IN-1:0]  det_vector,
  output logic               busy,
  output logic               done,
  output logic [FAULT_W-1:0] detected_cnt,
  output logic [FAULT_W-1:0] fault_cnt
);

  localparam int IW = vec_cnt_w(VEC_AW);
  localparam int SW = $clog2(SETTLE) + 1;

  state_t             state, nstate;
  logic [FAULT_W-1:0] nf_q, fid, det_cnt, flt_cnt;
  logic [IW-1:0]      nv_q, idx;
  logic [NUM_IN-1:0]  pi_q;
  logic               settle_zero, mismatch, last_vec, last_fault;

  assign mismatch   = out_good ^ out_faulty;
  assign last_vec   = (idx + IW'(1)) >= nv_q;
  assign last_fault = (fid == nf_q - FAULT_W'(1));

  fault_sim_settle_cnt #(.W(SW)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == S_FETCH),
    .load_val (SW'(SETTLE - 1)),
    .zero     (settle_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate       = state;
    fault_en     = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    det_valid    = 1'b0;
    det_fault_id = '0;
    det_vector   = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) nstate = (num_faults == '0) ? S_FIN : S_INJECT;
      end
      S_INJECT: begin
        fault_en = 1'b1;
        nstate   = (nv_q == '0) ? S_DROP : S_FETCH;
      end
      S_FETCH: begin
        fault_en = 1'b1;
        nstate   = S_APPLY;
      end
      S_APPLY: begin
        fault_en = 1'b1;
        if (settle_zero) nstate = S_COMPARE;
      end
      S_COMPARE: begin
        fault_en = 1'b1;
        if (mismatch) begin
          det_valid    = 1'b1;
          det_fault_id = fid;
          det_vector   = pi_q;
        end
        nstate = (mismatch || last_vec) ? S_DROP : S_FETCH;
      end
      S_DROP: nstate = last_fault ? S_FIN : S_INJECT;
      S_FIN: begin
        busy   = 1'b0;
        done   = 1'b1;
        nstate = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        nstate = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nf_q    <= '0;
      nv_q    <= '0;
      fid     <= '0;
      idx     <= '0;
      pi_q    <= '0;
      det_cnt <= '0;
      flt_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          nf_q    <= num_faults;
          nv_q    <= num_vecs;
          fid     <= '0;
          idx     <= '0;
          det_cnt <= '0;
          flt_cnt <= '0;
        end
        S_FETCH: pi_q <= vec_data;
        S_COMPARE: begin
          if (mismatch)      det_cnt <= det_cnt + 1'b1;
          else if (!last_vec) idx    <= idx + 1'b1;
          // Both circuits see all-zero inputs during the gap between faults.
          if (mismatch || last_vec) pi_q <= '0;
        end
        S_DROP: begin
          flt_cnt <= flt_cnt + 1'b1;
          if (!last_fault) begin
            fid <= fid + 1'b1;
            idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign vec_addr     = idx[VEC_AW-1:0];
  assign pi_vec       = pi_q;
  assign fault_id     = fid;
  assign detected_cnt = det_cnt;
  assign fault_cnt    = flt_cnt;

endmodule

// File: tb/tb_fault_sim_ctrl.sv
// Bench for fault_sim_ctrl: AND-gate circuit pair, trace model built from the sequencing rules.
module tb_fault_sim_ctrl;

  localparam int NUM_IN = 6, VEC_AW = 4, FAULT_W = 8, SETTLE = 2;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [FAULT_W-1:0] num_faults = '0;
  logic [VEC_AW:0]    num_vecs = '0;
  logic [VEC_AW-1:0]  vec_addr;
  logic [NUM_IN-1:0]  vec_data, pi_vec, det_vector;
  logic               fault_en, out_good, out_faulty, det_valid, busy, done;
  logic [FAULT_W-1:0] fault_id, det_fault_id, detected_cnt, fault_cnt;

  always #5 clk = ~clk;

  fault_sim_ctrl #(.NUM_IN(NUM_IN), .VEC_AW(VEC_AW), .FAULT_W(FAULT_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_faults(num_faults), .num_vecs(num_vecs),
    .vec_addr(vec_addr), .vec_data(vec_data), .pi_vec(pi_vec), .fault_en(fault_en),
    .fault_id(fault_id), .out_good(out_good), .out_faulty(out_faulty), .det_valid(det_valid),
    .det_fault_id(det_fault_id), .det_vector(det_vector), .busy(busy), .done(done),
    .detected_cnt(detected_cnt), .fault_cnt(fault_cnt)
  );

  // Vector memory and circuit pair: good = AND of inputs; fault k forces output to (k odd).
  logic [NUM_IN-1:0] mem [0:15];
  bit   [255:0]      undet;
  assign vec_data   = mem[vec_addr];
  assign out_good   = &pi_vec;
  assign out_faulty = (fault_en && !undet[fault_id]) ? fault_id[0] : out_good;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       fen, busy, done, dv, achk;
    logic [7:0] fid, dfid, dc, fc;
    logic [5:0] dvec, pi;
    logic [3:0] addr;
  } exp_t;

  exp_t q[$];

  function automatic bit detects(input int f, input logic [5:0] v);
    bit good = &v;
    bit bad_out = undet[f] ? good : f[0];
    return good != bad_out;
  endfunction

  task automatic push(input bit fen, input bit bsy, input bit dn, input int f, input bit dv,
                      input logic [5:0] dvec, input logic [5:0] pi, input int dc, input int fc,
                      input bit achk, input int addr);
    exp_t e;
    e.fen = fen; e.busy = bsy; e.done = dn; e.fid = 8'(f); e.dv = dv;
    e.dfid = dv ? 8'(f) : 8'd0; e.dvec = dv ? dvec : 6'd0; e.pi = pi;
    e.dc = 8'(dc); e.fc = 8'(fc); e.achk = achk; e.addr = 4'(addr);
    q.push_back(e);
  endtask

  // Cycle-by-cycle expectation of one run, starting the cycle after start is sampled.
  task automatic build(input int nf, input int nv);
    int dc = 0, fc = 0, lastf;
    logic [5:0] pv = '0;
    bit d;
    for (int f = 0; f < nf; f++) begin
      push(1, 1, 0, f, 0, 0, pv, dc, fc, 1, 0);                    // inject
      for (int v = 0; v < nv; v++) begin
        push(1, 1, 0, f, 0, 0, pv, dc, fc, 1, v);                  // fetch
        pv = mem[v];
        repeat (SETTLE) push(1, 1, 0, f, 0, 0, pv, dc, fc, 1, v);  // apply
        d = detects(f, pv);
        push(1, 1, 0, f, d, pv, pv, dc, fc, 1, v);                 // compare
        if (d) begin dc++; break; end
      end
      pv = '0;
      push(0, 1, 0, f, 0, 0, pv, dc, fc, 0, 0);                    // drop
      fc++;
    end
    lastf = (nf > 0) ? nf - 1 : 0;
    push(0, 0, 1, lastf, 0, 0, 0, dc, fc, 0, 0);                   // fin
    push(0, 0, 0, lastf, 0, 0, 0, dc, fc, 0, 0);                   // idle
  endtask

  always @(negedge clk) begin : compare
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("fault_en",     32'(fault_en),     32'(e.fen));
      chk("fault_id",     32'(fault_id),     32'(e.fid));
      chk("busy",         32'(busy),         32'(e.busy));
      chk("done",         32'(done),         32'(e.done));
      chk("det_valid",    32'(det_valid),    32'(e.dv));
      chk("det_fault_id", 32'(det_fault_id), 32'(e.dfid));
      chk("det_vector",   32'(det_vector),   32'(e.dvec));
      chk("pi_vec",       32'(pi_vec),       32'(e.pi));
      chk("detected_cnt", 32'(detected_cnt), 32'(e.dc));
      chk("fault_cnt",    32'(fault_cnt),    32'(e.fc));
      if (e.achk) chk("vec_addr", 32'(vec_addr), 32'(e.addr));
    end
  end

  // Observation monitors feeding the hand-computed checks.
  bit         det_mask [0:7];
  logic [5:0] det_vec_of [0:7];
  int         maxaddr [0:7];
  int         f2_cycles;
  bit         busy_seen;

  task automatic clr_mon();
    for (int i = 0; i < 8; i++) begin det_mask[i] = 0; det_vec_of[i] = '0; maxaddr[i] = -1; end
    f2_cycles = 0; busy_seen = 0;
  endtask

  always @(negedge clk) begin
    if (det_valid && det_fault_id < 8) begin
      det_mask[det_fault_id[2:0]]   = 1;
      det_vec_of[det_fault_id[2:0]] = det_vector;
    end
    if (fault_en && fault_id < 8 && int'(vec_addr) > maxaddr[fault_id[2:0]])
      maxaddr[fault_id[2:0]] = int'(vec_addr);
    if (busy && fault_id == 8'd2) f2_cycles++;
    if (busy) busy_seen = 1;
  end

  task automatic launch(input int nf, input int nv);
    @(posedge clk); #1;
    num_faults = 8'(nf); num_vecs = 5'(nv); start = 1'b1;
    @(posedge clk);
    build(nf, nv);
    #1 start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 2000) begin @(posedge clk); n++; end
    if (q.size() > 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 6'h3f;
    mem[0] = 6'h00;
    undet = '0;
    clr_mon();
    #2;
    chk("rst_fault_en", 32'(fault_en), 0);
    chk("rst_busy",     32'(busy), 0);
    chk("rst_done",     32'(done), 0);
    chk("rst_det",      32'(det_valid), 0);
    chk("rst_pi_vec",   32'(pi_vec), 0);
    chk("rst_addr",     32'(vec_addr), 0);
    chk("rst_fid",      32'(fault_id), 0);
    chk("rst_counts",   32'({detected_cnt, fault_cnt}), 0);
    @(negedge clk); rst_n = 1'b1;

    // Every fault detected; odd faults on 000000, even faults on 111111.
    clr_mon(); launch(4, 2); drain();
    chk("t1_detected", 32'(detected_cnt), 4);
    chk("t1_faults",   32'(fault_cnt), 4);
    chk("t1_vec_f0",   32'(det_vec_of[0]), 32'h3f);
    chk("t1_vec_f1",   32'(det_vec_of[1]), 32'h00);
    chk("t1_vec_f2",   32'(det_vec_of[2]), 32'h3f);
    chk("t1_vec_f3",   32'(det_vec_of[3]), 32'h00);

    // Fault 2 undetectable: walks both vectors, 2 + 2*(SETTLE+2) = 10 cycles.
    undet[2] = 1; clr_mon(); launch(4, 2); drain();
    chk("t2_detected", 32'(detected_cnt), 3);
    chk("t2_faults",   32'(fault_cnt), 4);
    chk("t2_f2_cycles", 32'(f2_cycles), 10);
    chk("t2_f2_nodet", 32'(det_mask[2]), 0);

    // Full 16-vector memory: fault 1 drops on vector 0, fault 2 walks every entry.
    clr_mon(); launch(3, 16); drain();
    chk("t3_f1_maxaddr", 32'(maxaddr[1]), 0);
    chk("t3_f2_maxaddr", 32'(maxaddr[2]), 15);
    chk("t3_detected",   32'(detected_cnt), 2);
    chk("t3_faults",     32'(fault_cnt), 3);
    undet = '0;

    // Empty fault list, then empty vector list.
    clr_mon(); launch(0, 2); drain();
    chk("t4_busy_seen", 32'(busy_seen), 0);
    chk("t4_counts",    32'({detected_cnt, fault_cnt}), 0);
    clr_mon(); launch(3, 0); drain();
    chk("t5_detected", 32'(detected_cnt), 0);
    chk("t5_faults",   32'(fault_cnt), 3);

    // Asynchronous reset during APPLY of fault 1 (cycle 12 of the run).
    clr_mon(); launch(4, 2);
    repeat (12) @(posedge clk);
    #1;
    chk("t6_pre_fid", 32'(fault_id), 1);
    chk("t6_pre_fen", 32'(fault_en), 1);
    q.delete();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_fault_en", 32'(fault_en), 0);
    chk("t6_busy",     32'(busy), 0);
    chk("t6_counts",   32'({detected_cnt, fault_cnt}), 0);
    chk("t6_pi_vec",   32'(pi_vec), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    launch(4, 2); drain();
    chk("t6_detected", 32'(detected_cnt), 4);
    chk("t6_faults",   32'(fault_cnt), 4);

    // start pulsed mid-run with different sizes must be ignored.
    clr_mon(); launch(4, 2);
    repeat (5) @(posedge clk);
    #1 num_faults = 8'd7; num_vecs = 5'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; num_faults = 8'd4; num_vecs = 5'd2;
    drain();
    chk("t7_detected", 32'(detected_cnt), 4);
    chk("t7_faults",   32'(fault_cnt), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
